// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder.
//   - FIFO_DEPTH_DEF : default request queue depth
//   - CMD_* / WIDTH_*: request command and width codes
//   - state_e        : responder FSM state encoding
//   - rq_t           : one queued request entry
//   - next_byte_addr : address of the second byte of a word (wraps at 16 bits)
package mem_pkg;

   localparam int FIFO_DEPTH_DEF = 2;

   localparam logic CMD_READ   = 1'b0;
   localparam logic CMD_WRITE  = 1'b1;
   localparam logic WIDTH_BYTE = 1'b0;
   localparam logic WIDTH_WORD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
      logic        width;
      logic        cmd;
      logic        tag;
   } rq_t;

   // 0xFFFF rolls over to 0x0000 by plain 16-bit truncation.
   function automatic logic [15:0] next_byte_addr(input logic [15:0] a);
      return a + 16'h0001;
   endfunction

endpackage

// File: rtl/rq_fifo.sv
// rq_fifo: synchronous request queue with registered occupancy count.
// Ports:
//   clk      : clock
//   i_rst    : synchronous active-high reset (empties the queue)
//   i_push   : enqueue i_wdata (ignored when full)
//   i_wdata  : entry to enqueue
//   i_pop    : dequeue head (ignored when empty)
//   o_rdata  : current head entry
//   o_full   : queue holds DEPTH entries
//   o_empty  : queue holds no entries
//   o_count  : number of entries held
module rq_fifo
   import mem_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  rq_t                      i_wdata,
   input  logic                     i_pop,
   output rq_t                      o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   rq_t           r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_full    = (r_count == CNT_FULL);
   assign o_empty   = (r_count == {(AW+1){1'b0}});
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Entry storage; contents need no reset because pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: queues memory requests and executes them, one byte per beat,
// on a byte-wide external bus; read results are returned with their tag.
// Ports:
//   clk, a_rst                       : clock, synchronous active-high reset
//   mem_rq_addr/data/prepare_addr    : request address, write data, MAR load
//   mem_rq_start/cmd/width, mem_t_id : enqueue strobe, read/write, byte/word, tag
//   mem_data_in/t_wr/wr              : read result, its tag, one-cycle strobe
//   hold, ovf                        : queue full, sticky dropped-request flag
//   bus_addr/dout/din/we/en/rdy      : byte-wide external bus
module mem_responder
   import mem_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        a_rst,
   input  logic [15:0] mem_rq_addr,
   input  logic [15:0] mem_rq_data,
   input  logic        mem_rq_prepare_addr,
   input  logic        mem_rq_start,
   input  logic        mem_rq_cmd,
   input  logic        mem_rq_width,
   input  logic        mem_t_id,
   output logic [15:0] mem_data_in,
   output logic        mem_data_t_wr,
   output logic        mem_data_wr,
   output logic        hold,
   output logic        ovf,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   input  logic [7:0]  bus_din,
   output logic        bus_we,
   output logic        bus_en,
   input  logic        bus_rdy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   state_e      r_state;
   logic [15:0] r_mar;
   logic        r_ovf;
   logic [7:0]  r_lo;
   logic [15:0] r_bus_addr;
   logic [7:0]  r_bus_dout;
   logic        r_bus_we;
   logic        r_bus_en;
   logic [15:0] r_data_in;
   logic        r_data_t_wr;
   logic        r_data_wr;

   rq_t         w_new;
   rq_t         w_head;
   logic        w_full;
   logic        w_empty;
   logic [AW:0] w_count;
   logic        w_pop;

   // A same-cycle prepare_addr supplies the address directly, bypassing MAR.
   assign w_new.addr  = mem_rq_prepare_addr ? mem_rq_addr : r_mar;
   assign w_new.data  = mem_rq_data;
   assign w_new.width = mem_rq_width;
   assign w_new.cmd   = mem_rq_cmd;
   assign w_new.tag   = mem_t_id;
   assign w_pop       = (r_state == ST_RESP) & ~w_empty;

   rq_fifo #(.DEPTH(FIFO_DEPTH)) u_rq_fifo (
      .clk     (clk),
      .i_rst   (a_rst),
      .i_push  (mem_rq_start),
      .i_wdata (w_new),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign hold          = w_full;
   assign ovf           = r_ovf;
   assign bus_addr      = r_bus_addr;
   assign bus_dout      = r_bus_dout;
   assign bus_we        = r_bus_we;
   assign bus_en        = r_bus_en;
   assign mem_data_in   = r_data_in;
   assign mem_data_t_wr = r_data_t_wr;
   assign mem_data_wr   = r_data_wr;

   // Address register and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         r_mar <= 16'h0000;
         r_ovf <= 1'b0;
      end else begin
         if (mem_rq_prepare_addr) r_mar <= mem_rq_addr;
         if (mem_rq_start && w_full) r_ovf <= 1'b1;
      end
   end

   // Transfer FSM; bus and result outputs are set on the edge entering each state.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         r_state     <= ST_IDLE;
         r_lo        <= 8'h00;
         r_bus_addr  <= 16'h0000;
         r_bus_dout  <= 8'h00;
         r_bus_we    <= 1'b0;
         r_bus_en    <= 1'b0;
         r_data_in   <= 16'h0000;
         r_data_t_wr <= 1'b0;
         r_data_wr   <= 1'b0;
      end else begin
         r_data_wr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_count != {(AW+1){1'b0}}) begin
                  r_state    <= ST_LO;
                  r_bus_en   <= 1'b1;
                  r_bus_we   <= w_head.cmd;
                  r_bus_addr <= w_head.addr;
                  r_bus_dout <= w_head.data[7:0];
               end
            end
            ST_LO: begin
               if (bus_rdy) begin
                  r_lo <= bus_din;
                  if (w_head.width == WIDTH_WORD) begin
                     r_state    <= ST_HI;
                     r_bus_addr <= next_byte_addr(w_head.addr);
                     r_bus_dout <= w_head.data[15:8];
                  end else begin
                     r_state  <= ST_RESP;
                     r_bus_en <= 1'b0;
                     r_bus_we <= 1'b0;
                     if (w_head.cmd == CMD_READ) begin
                        r_data_wr   <= 1'b1;
                        r_data_in   <= {8'h00, bus_din};
                        r_data_t_wr <= w_head.tag;
                     end
                  end
               end
            end
            ST_HI: begin
               if (bus_rdy) begin
                  r_state  <= ST_RESP;
                  r_bus_en <= 1'b0;
                  r_bus_we <= 1'b0;
                  if (w_head.cmd == CMD_READ) begin
                     r_data_wr   <= 1'b1;
                     r_data_in   <= {bus_din, r_lo};
                     r_data_t_wr <= w_head.tag;
                  end
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_bus_en <= 1'b0;
               r_bus_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a
// request-queue reference model kept in the bench.
module tb_mem_responder;

   logic        clk;
   logic        a_rst;
   logic [15:0] mem_rq_addr;
   logic [15:0] mem_rq_data;
   logic        mem_rq_prepare_addr;
   logic        mem_rq_start;
   logic        mem_rq_cmd;
   logic        mem_rq_width;
   logic        mem_t_id;
   logic [15:0] mem_data_in;
   logic        mem_data_t_wr;
   logic        mem_data_wr;
   logic        hold;
   logic        ovf;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din;
   logic        bus_we;
   logic        bus_en;
   logic        bus_rdy;

   logic        model_mode;
   logic [7:0]  tb_din;

   int checks;
   int failures;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        width;
      logic        cmd;
      logic        tag;
   } req_s;

   // Memory contents seen by reads: a fixed function of the byte address.
   function automatic logic [7:0] mb(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign bus_din = model_mode ? mb(bus_addr) : tb_din;

   mem_responder #(.FIFO_DEPTH(2)) dut (
      .clk                 (clk),
      .a_rst               (a_rst),
      .mem_rq_addr         (mem_rq_addr),
      .mem_rq_data         (mem_rq_data),
      .mem_rq_prepare_addr (mem_rq_prepare_addr),
      .mem_rq_start        (mem_rq_start),
      .mem_rq_cmd          (mem_rq_cmd),
      .mem_rq_width        (mem_rq_width),
      .mem_t_id            (mem_t_id),
      .mem_data_in         (mem_data_in),
      .mem_data_t_wr       (mem_data_t_wr),
      .mem_data_wr         (mem_data_wr),
      .hold                (hold),
      .ovf                 (ovf),
      .bus_addr            (bus_addr),
      .bus_dout            (bus_dout),
      .bus_din             (bus_din),
      .bus_we              (bus_we),
      .bus_en              (bus_en),
      .bus_rdy             (bus_rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_rq_start        = 1'b0;
      mem_rq_prepare_addr = 1'b0;
   endtask

   task automatic start_req(input logic [15:0] a, input logic [15:0] d, input logic prep,
                            input logic cmd, input logic w, input logic t);
      mem_rq_addr         = a;
      mem_rq_data         = d;
      mem_rq_prepare_addr = prep;
      mem_rq_start        = 1'b1;
      mem_rq_cmd          = cmd;
      mem_rq_width        = w;
      mem_t_id            = t;
   endtask

   task automatic test_reset();
      a_rst = 1'b1;
      step();
      step();
      checks++;
      if ({hold, ovf, bus_en, bus_we, bus_addr, bus_dout, mem_data_wr, mem_data_in, mem_data_t_wr} !== 46'd0) begin
         failures++;
         $display("FAIL reset_outputs: got hold=%0b ovf=%0b en=%0b we=%0b addr=%h dout=%h wr=%0b din=%h tag=%0b expected all zero",
                  hold, ovf, bus_en, bus_we, bus_addr, bus_dout, mem_data_wr, mem_data_in, mem_data_t_wr);
      end
      a_rst = 1'b0;
      step();
      checks++;
      if (bus_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_bus_en: got %0b expected 0", bus_en);
      end
   endtask

   task automatic test_byte_read();
      model_mode = 1'b0; tb_din = 8'hAB; bus_rdy = 1'b1;
      start_req(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); idle_inputs();
      checks++;
      if (bus_en !== 1'b0) begin failures++; $display("FAIL byte_rd_c1_en: got %0b expected 0", bus_en); end
      step();
      checks++;
      if ({bus_en, bus_we, bus_addr, mem_data_wr} !== {1'b1, 1'b0, 16'h1234, 1'b0}) begin
         failures++;
         $display("FAIL byte_rd_c2_bus: got en=%0b we=%0b addr=%h wr=%0b expected en=1 we=0 addr=1234 wr=0",
                  bus_en, bus_we, bus_addr, mem_data_wr);
      end
      step();
      checks++;
      if ({mem_data_wr, mem_data_in, mem_data_t_wr, bus_en} !== {1'b1, 16'h00AB, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL byte_rd_c3_resp: got wr=%0b data=%h tag=%0b en=%0b expected wr=1 data=00ab tag=1 en=0",
                  mem_data_wr, mem_data_in, mem_data_t_wr, bus_en);
      end
      step();
      checks++;
      if (mem_data_wr !== 1'b0) begin failures++; $display("FAIL byte_rd_c4_strobe: got %0b expected 0", mem_data_wr); end
   endtask

   task automatic test_word_read_wrap();
      model_mode = 1'b0; bus_rdy = 1'b1; tb_din = 8'h00;
      start_req(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      step(); idle_inputs();
      step();
      checks++;
      if ({bus_en, bus_addr} !== {1'b1, 16'hFFFF}) begin
         failures++; $display("FAIL word_rd_lo_addr: got en=%0b addr=%h expected en=1 addr=ffff", bus_en, bus_addr);
      end
      tb_din = 8'h34;
      step();
      checks++;
      if ({bus_en, bus_addr} !== {1'b1, 16'h0000}) begin
         failures++; $display("FAIL word_rd_hi_addr: got en=%0b addr=%h expected en=1 addr=0000", bus_en, bus_addr);
      end
      tb_din = 8'h12;
      step();
      checks++;
      if ({mem_data_wr, mem_data_in, mem_data_t_wr} !== {1'b1, 16'h1234, 1'b0}) begin
         failures++; $display("FAIL word_rd_resp: got wr=%0b data=%h tag=%0b expected wr=1 data=1234 tag=0",
                              mem_data_wr, mem_data_in, mem_data_t_wr);
      end
      step();
   endtask

   task automatic test_word_write();
      int strobes;
      strobes = 0;
      model_mode = 1'b1; bus_rdy = 1'b1;
      mem_rq_addr = 16'h0200; mem_rq_prepare_addr = 1'b1; mem_rq_start = 1'b0;
      step();
      // Address comes from MAR, not from the unrelated bus value presented now.
      start_req(16'h7777, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1);
      step(); idle_inputs();
      step();
      if (mem_data_wr) strobes++;
      checks++;
      if ({bus_en, bus_we, bus_addr, bus_dout} !== {1'b1, 1'b1, 16'h0200, 8'hEF}) begin
         failures++; $display("FAIL word_wr_lo: got en=%0b we=%0b addr=%h dout=%h expected 1 1 0200 ef",
                              bus_en, bus_we, bus_addr, bus_dout);
      end
      step();
      if (mem_data_wr) strobes++;
      checks++;
      if ({bus_en, bus_we, bus_addr, bus_dout} !== {1'b1, 1'b1, 16'h0201, 8'hBE}) begin
         failures++; $display("FAIL word_wr_hi: got en=%0b we=%0b addr=%h dout=%h expected 1 1 0201 be",
                              bus_en, bus_we, bus_addr, bus_dout);
      end
      step();
      if (mem_data_wr) strobes++;
      checks++;
      if ({bus_en, bus_we} !== 2'b00) begin
         failures++; $display("FAIL word_wr_resp_bus: got en=%0b we=%0b expected 0 0", bus_en, bus_we);
      end
      step();
      if (mem_data_wr) strobes++;
      checks++;
      if (strobes !== 0) begin failures++; $display("FAIL word_wr_no_strobe: got %0d strobes expected 0", strobes); end
   endtask

   task automatic test_overflow();
      int n;
      logic [15:0] rd [2];
      logic        rt [2];
      n = 0;
      model_mode = 1'b1; bus_rdy = 1'b0;
      start_req(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (hold !== 1'b0) begin failures++; $display("FAIL ovf_hold_after1: got %0b expected 0", hold); end
      start_req(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (hold !== 1'b1) begin failures++; $display("FAIL ovf_hold_after2: got %0b expected 1", hold); end
      start_req(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); idle_inputs();
      checks++;
      if ({ovf, hold} !== 2'b11) begin failures++; $display("FAIL ovf_flag: got ovf=%0b hold=%0b expected 1 1", ovf, hold); end
      bus_rdy = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (mem_data_wr) begin
            if (n < 2) begin rd[n] = mem_data_in; rt[n] = mem_data_t_wr; end
            n++;
         end
      end
      checks++;
      if (n !== 2) begin failures++; $display("FAIL ovf_resp_count: got %0d expected 2", n); end
      if (n >= 2) begin
         checks++;
         if ({rd[0], rt[0], rd[1], rt[1]} !== {8'h00, mb(16'h0010), 1'b0, 8'h00, mb(16'h0020), 1'b1}) begin
            failures++; $display("FAIL ovf_resp_order: got %h/%0b %h/%0b expected %h/0 %h/1",
                                 rd[0], rt[0], rd[1], rt[1], {8'h00, mb(16'h0010)}, {8'h00, mb(16'h0020)});
         end
      end
      checks++;
      if ({ovf, hold} !== 2'b10) begin failures++; $display("FAIL ovf_sticky: got ovf=%0b hold=%0b expected 1 0", ovf, hold); end
   endtask

   task automatic test_hi_stall();
      int strobes;
      strobes = 0;
      model_mode = 1'b1; bus_rdy = 1'b1;
      start_req(16'h4000, 16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b1);
      step(); idle_inputs();
      step();
      step();
      bus_rdy = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         checks++;
         if ({bus_en, bus_addr, bus_dout, mem_data_wr} !== {1'b1, 16'h4001, 8'hCA, 1'b0}) begin
            failures++; $display("FAIL hi_stall_c%0d: got en=%0b addr=%h dout=%h wr=%0b expected 1 4001 ca 0",
                                 c, bus_en, bus_addr, bus_dout, mem_data_wr);
         end
         if (c == 6) bus_rdy = 1'b1;
         step();
      end
      checks++;
      if ({mem_data_wr, mem_data_in, mem_data_t_wr} !== {1'b1, mb(16'h4001), mb(16'h4000), 1'b1}) begin
         failures++; $display("FAIL hi_stall_resp: got wr=%0b data=%h tag=%0b expected 1 %h 1",
                              mem_data_wr, mem_data_in, mem_data_t_wr, {mb(16'h4001), mb(16'h4000)});
      end
      for (int i = 0; i < 4; i++) begin
         if (mem_data_wr) strobes++;
         step();
      end
      checks++;
      if (strobes !== 1) begin failures++; $display("FAIL hi_stall_single: got %0d strobes expected 1", strobes); end
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      model_mode = 1'b1; bus_rdy = 1'b1;
      start_req(16'h5000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      step(); idle_inputs();
      step();
      step();
      a_rst = 1'b1;
      start_req(16'h6000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); idle_inputs();
      a_rst = 1'b0;
      checks++;
      if ({bus_en, bus_we, mem_data_wr, hold, ovf} !== 5'b00000) begin
         failures++; $display("FAIL rst_mid_outputs: got en=%0b we=%0b wr=%0b hold=%0b ovf=%0b expected all 0",
                              bus_en, bus_we, mem_data_wr, hold, ovf);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus_en || mem_data_wr) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL rst_mid_queue_empty: got %0d active cycles expected 0", bad); end
      start_req(16'h9999, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step(); idle_inputs();
      step();
      checks++;
      if ({bus_en, bus_addr} !== {1'b1, 16'h0000}) begin
         failures++; $display("FAIL rst_mar_cleared: got en=%0b addr=%h expected 1 0000", bus_en, bus_addr);
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_random();
      req_s        rq[$];
      logic [16:0] rsp[$];
      req_s        r;
      logic [15:0] mar;
      logic [15:0] exp_a;
      logic [7:0]  exp_d;
      logic [16:0] e;
      int          beat;
      int          issued;
      int          reads;
      int          seen;
      int          bad_we;
      int          cyc;
      beat = 0; issued = 0; reads = 0; seen = 0; bad_we = 0; cyc = 0;
      a_rst = 1'b1; idle_inputs(); model_mode = 1'b1; bus_rdy = 1'b1;
      step();
      a_rst = 1'b0;
      mar = 16'h0000;
      while (!(issued == 60 && rq.size() == 0 && rsp.size() == 0) && cyc < 3000) begin
         cyc++;
         if (mem_data_wr) begin
            checks++;
            if (rsp.size() == 0) begin
               failures++; $display("FAIL rand_unexpected_strobe: got data=%h tag=%0b expected none", mem_data_in, mem_data_t_wr);
            end else begin
               e = rsp.pop_front();
               seen++;
               if ({mem_data_in, mem_data_t_wr} !== e) begin
                  failures++; $display("FAIL rand_resp: got %h/%0b expected %h/%0b", mem_data_in, mem_data_t_wr, e[16:1], e[0]);
               end
            end
         end
         if (bus_we && !bus_en) bad_we++;
         idle_inputs();
         mem_rq_prepare_addr = 1'($urandom_range(0, 1));
         mem_rq_addr         = 16'($urandom);
         mem_rq_data         = 16'($urandom);
         mem_rq_cmd          = 1'($urandom_range(0, 1));
         mem_rq_width        = 1'($urandom_range(0, 1));
         mem_t_id            = 1'($urandom_range(0, 1));
         if (issued < 60 && !hold && $urandom_range(0, 1) == 1) begin
            mem_rq_start = 1'b1;
            r.addr = mem_rq_prepare_addr ? mem_rq_addr : mar;
            r.data = mem_rq_data; r.width = mem_rq_width; r.cmd = mem_rq_cmd; r.tag = mem_t_id;
            rq.push_back(r);
            issued++;
            if (!r.cmd) reads++;
         end
         if (mem_rq_prepare_addr) mar = mem_rq_addr;
         bus_rdy = ($urandom_range(0, 3) != 0);
         if (bus_en && bus_rdy) begin
            checks++;
            if (rq.size() == 0) begin
               failures++; $display("FAIL rand_unexpected_beat: got addr=%h expected no bus activity", bus_addr);
            end else begin
               r = rq[0];
               exp_a = (beat == 0) ? r.addr : 16'(r.addr + 16'd1);
               exp_d = (beat == 0) ? r.data[7:0] : r.data[15:8];
               if ({bus_addr, bus_we} !== {exp_a, r.cmd} || (r.cmd && bus_dout !== exp_d)) begin
                  failures++; $display("FAIL rand_beat: got addr=%h we=%0b dout=%h expected addr=%h we=%0b dout=%h",
                                       bus_addr, bus_we, bus_dout, exp_a, r.cmd, exp_d);
               end
               if (beat == 0 && r.width) begin
                  beat = 1;
               end else begin
                  if (!r.cmd) begin
                     if (r.width) rsp.push_back({mb(16'(r.addr + 16'd1)), mb(r.addr), r.tag});
                     else         rsp.push_back({8'h00, mb(r.addr), r.tag});
                  end
                  void'(rq.pop_front());
                  beat = 0;
               end
            end
         end
         step();
      end
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         if (mem_data_wr) seen++;
         step();
      end
      checks++;
      if (cyc >= 3000) begin failures++; $display("FAIL rand_timeout: got %0d cycles expected < 3000", cyc); end
      checks++;
      if (seen !== reads) begin failures++; $display("FAIL rand_resp_count: got %0d expected %0d", seen, reads); end
      checks++;
      if ({bad_we, ovf} !== {32'd0, 1'b0}) begin
         failures++; $display("FAIL rand_we_ovf: got we_without_en=%0d ovf=%0b expected 0 0", bad_we, ovf);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      model_mode = 1'b0; tb_din = 8'h00; bus_rdy = 1'b1;
      mem_rq_addr = 16'h0000; mem_rq_data = 16'h0000; mem_rq_cmd = 1'b0;
      mem_rq_width = 1'b0; mem_t_id = 1'b0;
      idle_inputs();
      a_rst = 1'b1;
      test_reset();
      test_byte_read();
      test_word_read_wrap();
      test_word_write();
      test_overflow();
      test_hi_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
